// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states, default width,
// and the quotient returned for a zero divisor.
package hilo_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_DIVIDE
    } state_e;

    localparam int unsigned HILO_WIDTH = 32;

    // Wide enough for any supported WIDTH; consumers slice the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and record the quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        shifted  = {rem_in, quot_in[WIDTH-1]};
        fits     = shifted >= {1'b0, divisor};
        quot_out = {quot_in[WIDTH-2:0], fits};
        // The partial remainder stays below the divisor, so WIDTH bits always hold it.
        rem_out  = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO register pair with MULT capture, MTHI/MTLO writes and an iterative DIV/DIVU.
// Define HILO_BYPASS_EN to forward the current cycle's pending write onto hi/lo.
import hilo_pkg::*;

module hilo_muldiv #(
    parameter int unsigned WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic             mult_wr,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_e           state_q;
    logic             busy_q;
    logic             dz_pulse_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] rem_q, quot_q, dvsr_q, dividend_q;
    logic             negq_q, negr_q, dzero_q;

    logic [WIDTH-1:0] rem_d, quot_d;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_neg, b_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (dvsr_q),
        .rem_out  (rem_d),
        .quot_out (quot_d)
    );

    always_comb begin
        a_neg = div_signed & dividend[WIDTH-1];
        b_neg = div_signed & divisor[WIDTH-1];
        a_mag = a_neg ? -dividend : dividend;
        b_mag = b_neg ? -divisor : divisor;
        q_fix = negq_q ? -quot_d : quot_d;
        r_fix = negr_q ? -rem_d : rem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            dz_pulse_q <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dzero_q    <= 1'b0;
        end else begin
            dz_pulse_q <= 1'b0;
            // Any architectural write abandons an in-flight division.
            if (mult_wr) begin
                hi_q    <= alu_hi;
                lo_q    <= alu_lo;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (mthi || mtlo) begin
                if (mthi) hi_q <= wr_data;
                if (mtlo) lo_q <= wr_data;
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (div_start) begin
                            rem_q      <= '0;
                            quot_q     <= a_mag;
                            dvsr_q     <= b_mag;
                            dividend_q <= dividend;
                            negq_q     <= a_neg ^ b_neg;
                            negr_q     <= a_neg;
                            dzero_q    <= (divisor == '0);
                            cnt_q      <= CW'(WIDTH - 1);
                            state_q    <= ST_DIVIDE;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_DIVIDE: begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            if (dzero_q) begin
                                lo_q <= DIV_ZERO_QUOT[WIDTH-1:0];
                                hi_q <= dividend_q;
                            end else begin
                                lo_q <= q_fix;
                                hi_q <= r_fix;
                            end
                            dz_pulse_q <= dzero_q;
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HILO_BYPASS_EN
    always_comb begin
        hi = hi_q;
        lo = lo_q;
        if (mult_wr) begin
            hi = alu_hi;
            lo = alu_lo;
        end else begin
            if (mthi) hi = wr_data;
            if (mtlo) lo = wr_data;
        end
    end
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

    assign busy        = busy_q;
    assign div_by_zero = dz_pulse_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model (honours HILO_BYPASS_EN).
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_hi = '0, alu_lo = '0;
    logic        mult_wr = 1'b0, div_start = 1'b0, div_signed = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi, lo;
    logic        busy, div_by_zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: architectural HI/LO plus an outstanding division with its
    // precomputed result and the number of edges left until it lands.
    logic [31:0] m_hi = '0, m_lo = '0;
    bit          m_busy = 1'b0, m_dz = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res_hi, m_res_lo;
    bit          m_res_dz;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_hi      (alu_hi),
        .alu_lo      (alu_lo),
        .mult_wr     (mult_wr),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wr_data     (wr_data),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output bit dz);
        longint sa, sb;
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic void model_step();
        m_dz = 1'b0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
        end else if (mult_wr) begin
            m_hi = alu_hi; m_lo = alu_lo; m_busy = 1'b0;
        end else if (mthi || mtlo) begin
            if (mthi) m_hi = wr_data;
            if (mtlo) m_lo = wr_data;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_res_hi; m_lo = m_res_lo; m_dz = m_res_dz; m_busy = 1'b0;
            end
        end else if (div_start) begin
            ref_div(div_signed, dividend, divisor, m_res_lo, m_res_hi, m_res_dz);
            m_busy = 1'b1;
            m_left = 32;
        end
    endfunction

    always @(negedge clk) begin
        logic [31:0] e_hi, e_lo;
        if (chk_en) begin
            e_hi = m_hi;
            e_lo = m_lo;
`ifdef HILO_BYPASS_EN
            if (mult_wr) begin
                e_hi = alu_hi; e_lo = alu_lo;
            end else begin
                if (mthi) e_hi = wr_data;
                if (mtlo) e_lo = wr_data;
            end
`endif
            chk("model_hi", hi, e_hi);
            chk("model_lo", lo, e_lo);
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_dz", 32'(div_by_zero), 32'(m_dz));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        mult_wr = 1'b0; mthi = 1'b0; mtlo = 1'b0; div_start = 1'b0;
    endtask

    task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
        div_signed = s; dividend = a; divisor = b; div_start = 1'b1;
        tick();
    endtask

    // Launch a division and count busy cycles, bounded so a stuck busy cannot hang the run.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, output int n);
        launch(s, a, b);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dz", 32'(div_by_zero), 32'h0);

        alu_hi = 32'h1; alu_lo = 32'h2; mult_wr = 1'b1;
        tick();
        chk("mult_hi", hi, 32'h1);
        chk("mult_lo", lo, 32'h2);
        chk("mult_busy", 32'(busy), 32'h0);

        run_div(1'b0, 32'd100, 32'd7, n);
        chk("divu_cycles", 32'(n), 32'd32);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        chk("divu_dz", 32'(div_by_zero), 32'h0);

        run_div(1'b1, 32'hFFFFFFF9, 32'd2, n);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, n);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);

        run_div(1'b0, 32'd5, 32'd0, n);
        chk("dz_cycles", 32'(n), 32'd32);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'd5);
        chk("dz_pulse", 32'(div_by_zero), 32'h1);
        tick();
        chk("dz_pulse_end", 32'(div_by_zero), 32'h0);

        launch(1'b0, 32'd1000, 32'd3);
        repeat (9) tick();
        chk("abort_pre_busy", 32'(busy), 32'h1);
        wr_data = 32'hAA; mtlo = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_lo", lo, 32'hAA);
        chk("abort_hi", hi, 32'd5);
        repeat (40) tick();
        chk("abort_lo_kept", lo, 32'hAA);
        chk("abort_hi_kept", hi, 32'd5);

        launch(1'b0, 32'd1000, 32'd3);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);

`ifdef HILO_BYPASS_EN
        wr_data = 32'h55; mthi = 1'b1;
        #1;
        chk("bypass_hi", hi, 32'h55);
        tick();
        chk("bypass_hi_reg", hi, 32'h55);
`endif

        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            mult_wr    = ($urandom_range(0, 149) == 0);
            mthi       = ($urandom_range(0, 149) == 0);
            mtlo       = ($urandom_range(0, 149) == 0);
            div_start  = ($urandom_range(0, 3) == 0);
            div_signed = 1'($urandom_range(0, 1));
            alu_hi     = $urandom;
            alu_lo     = $urandom;
            wr_data    = $urandom;
            dividend   = pick();
            divisor    = pick();
            tick();
        end
        reset = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
